fp_led_sequencer: RTL

//  LED pattern engine between the LED-control WireIn and the board LED pins.

---
 rtl/fp_led_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fp_led_sequencer.sv
// LED pattern engine: decodes the host control word into static, blink, chase or
// count patterns with PWM brightness and reports pattern/mode/step on a status word.
module fp_led_sequencer #(
    parameter int N_LED          = 6,
    parameter int TICK_DIV       = 100800,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic             okClk,
    input  logic             rst_n,
    input  logic [31:0]      ctrl,
    output logic [N_LED-1:0] led,
    output logic [31:0]      status
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [23:0]      ctrl_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [7:0]       step_div_q, step_div_d;
    logic [7:0]       step_q, step_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0] pat_q, pat_d;
    logic             on_q, on_d;
    mode_e            mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [31:0]      status_q, status_d;

    logic             tick, step_evt, mode_chg, pwm_on;
    mode_e            mode_req;
    logic [7:0]       duty, rate, mask8, pat_ext;
    logic [N_LED-1:0] mask_w;
    logic             unused_ctrl;

    assign mode_req    = mode_e'(ctrl_q[7:6]);
    assign duty        = ctrl_q[15:8];
    assign rate        = ctrl_q[23:16];
    assign mask8       = {2'b00, ctrl_q[5:0]};
    assign mask_w      = mask8[N_LED-1:0];
    assign unused_ctrl = ^ctrl[31:24];

    // State register
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            tick_cnt_q <= '0;
            step_div_q <= '0;
            step_q     <= '0;
            pwm_cnt_q  <= '0;
            pat_q      <= '0;
            on_q       <= 1'b1;
            mode_q     <= MODE_STATIC;
            led_q      <= {N_LED{LED_ACTIVE_LOW}};
            status_q   <= '0;
        end else begin
            ctrl_q     <= ctrl[23:0];
            tick_cnt_q <= tick_cnt_d;
            step_div_q <= step_div_d;
            step_q     <= step_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pat_q      <= pat_d;
            on_q       <= on_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            status_q   <= status_d;
        end
    end

    // Next-state: prescaler, step timer, mode transitions and pattern update
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        step_evt   = 1'b0;
        step_div_d = step_div_q;
        if (tick) begin
            if (step_div_q >= rate) begin
                step_div_d = '0;
                step_evt   = 1'b1;
            end else begin
                step_div_d = step_div_q + 8'd1;
            end
        end
        mode_chg  = (mode_req != mode_q);
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        step_d    = step_q;
        on_d      = on_q;
        pat_d     = pat_q;
        mode_d    = mode_q;
        if (mode_chg) begin
            // A mode change overrides any step event landing in the same cycle.
            mode_d     = mode_req;
            step_div_d = '0;
            step_d     = '0;
            pwm_cnt_d  = '0;
            on_d       = 1'b1;
            case (mode_req)
                MODE_STATIC, MODE_BLINK: pat_d = mask_w;
                MODE_CHASE:              pat_d = N_LED'(1);
                default:                 pat_d = '0;
            endcase
        end else begin
            if (step_evt) begin
                step_d = step_q + 8'd1;
                on_d   = ~on_q;
            end
            case (mode_q)
                MODE_STATIC: pat_d = mask_w;
                MODE_BLINK:  pat_d = on_d ? mask_w : '0;
                MODE_CHASE:  if (step_evt) pat_d = (pat_q << 1) | (pat_q >> (N_LED - 1));
                default:     pat_d = step_d[N_LED-1:0];
            endcase
        end
    end

    // Outputs are built from next-state values so led/status sit one cycle after ctrl_q.
    always_comb begin
        pwm_on   = (duty == 8'hFF) || (pwm_cnt_q < duty);
        led_d    = (pat_d & {N_LED{pwm_on}}) ^ {N_LED{LED_ACTIVE_LOW}};
        pat_ext  = 8'(pat_d);
        status_d = {16'h0000, step_d, mode_d, pat_ext[5:0]};
    end

    assign led    = led_q;
    assign status = status_q;

endmodule
